// File: rtl/dac_spi_frame_tx_pkg.sv
// Shared types, constants and frame assembly for the dual-channel DAC SPI serializer.
package dac_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    localparam int unsigned FRAME_BITS = 24;

    localparam logic [1:0] PD_NORMAL   = 2'b00;
    localparam logic [1:0] PD_1K       = 2'b01;
    localparam logic [1:0] PD_100K     = 2'b10;
    localparam logic [1:0] PD_TRISTATE = 2'b11;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [1:0]  pd,
        input logic [15:0] word
    );
        return {6'b0, pd, word};
    endfunction

endpackage

// File: rtl/dac_spi_frame_tx_lane.sv
// One DAC channel: frame shift register plus registered SYNC/SCLK/DIN pins.
module dac_spi_lane
    import dac_spi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  advance,
    input  logic                  active,
    input  logic                  sclk_hi,
    input  logic [FRAME_BITS-1:0] frame_in,
    input  logic                  en_in,
    output logic                  sync_n,
    output logic                  sclk,
    output logic                  din
);

    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic                  en_q, en_d;
    logic                  sync_q, sync_d;
    logic                  sclk_q, sclk_d;
    logic                  din_q, din_d;

    // Pins are computed from the next shift/enable values so they line up with the core's next phase.
    always_comb begin
        shift_d = shift_q;
        en_d    = en_q;
        if (load) begin
            shift_d = frame_in;
            en_d    = en_in;
        end else if (advance) begin
            shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        end
        sync_d = !(active && en_d);
        sclk_d = !(active && en_d && !sclk_hi);
        din_d  = active && en_d && shift_d[FRAME_BITS-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            en_q    <= 1'b0;
            sync_q  <= 1'b1;
            sclk_q  <= 1'b1;
            din_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            en_q    <= en_d;
            sync_q  <= sync_d;
            sclk_q  <= sclk_d;
            din_q   <= din_d;
        end
    end

    assign sync_n = sync_q;
    assign sclk   = sclk_q;
    assign din    = din_q;

endmodule

// File: rtl/dac_spi_frame_tx.sv
// Dual SPI DAC frame serializer: shared FSM/counter core driving two lanes in lockstep.
// Optional per-channel power-down field: define DAC_SPI_POWERDOWN_EN to add the pd_mode input.
module dac_spi_frame_tx
    import dac_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV          = 2,
    parameter int unsigned SYNC_HIGH_CYCLES = 2
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dac_word_1,
    input  logic [15:0] dac_word_2,
    input  logic [1:0]  DAC_en,
`ifdef DAC_SPI_POWERDOWN_EN
    input  logic [3:0]  pd_mode,
`endif
    output logic [1:0]  DAC_SYNC,
    output logic [1:0]  DAC_SCLK,
    output logic [1:0]  DAC_DIN,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [4:0] BIT_LAST = 5'(FRAME_BITS - 1);
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [3:0] GAP_LAST = 4'(SYNC_HIGH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [4:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] div_cnt_q, div_cnt_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       phase_q, phase_d;     // 0: SCLK-high half, 1: SCLK-low half
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;
    logic       load, advance, active, sclk_hi;
    logic [1:0] pd_1, pd_2;

`ifdef DAC_SPI_POWERDOWN_EN
    assign pd_1 = pd_mode[1:0];
    assign pd_2 = pd_mode[3:2];
`else
    assign pd_1 = PD_NORMAL;
    assign pd_2 = PD_NORMAL;
`endif

    assign in_ready = (state_q == IDLE);

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        div_cnt_d    = div_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        phase_d      = phase_q;
        frame_done_d = 1'b0;
        load         = 1'b0;
        advance      = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    phase_d   = 1'b0;
                    load      = 1'b1;
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else if (bit_cnt_q == BIT_LAST) begin
                        state_d      = GAP;
                        gap_cnt_d    = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        phase_d   = 1'b0;
                        advance   = 1'b1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 4'd1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        active  = (state_d == SHIFT);
        sclk_hi = !phase_d;
    end

    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            div_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            phase_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            div_cnt_q    <= div_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            phase_q      <= phase_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    dac_spi_lane u_lane_1 (
        .clk      (dataclk),
        .rst_n    (reset),
        .load     (load),
        .advance  (advance),
        .active   (active),
        .sclk_hi  (sclk_hi),
        .frame_in (build_frame(pd_1, dac_word_1)),
        .en_in    (DAC_en[0]),
        .sync_n   (DAC_SYNC[0]),
        .sclk     (DAC_SCLK[0]),
        .din      (DAC_DIN[0])
    );

    dac_spi_lane u_lane_2 (
        .clk      (dataclk),
        .rst_n    (reset),
        .load     (load),
        .advance  (advance),
        .active   (active),
        .sclk_hi  (sclk_hi),
        .frame_in (build_frame(pd_2, dac_word_2)),
        .en_in    (DAC_en[1]),
        .sync_n   (DAC_SYNC[1]),
        .sclk     (DAC_SCLK[1]),
        .din      (DAC_DIN[1])
    );

endmodule

// File: tb/tb_dac_spi_frame_tx.sv
// Directed bench for dac_spi_frame_tx; covers the DAC_SPI_POWERDOWN_EN path when that macro is defined.
module tb_dac_spi_frame_tx;

    logic        dataclk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dac_word_1;
    logic [15:0] dac_word_2;
    logic [1:0]  DAC_en;
    logic [1:0]  DAC_SYNC;
    logic [1:0]  DAC_SCLK;
    logic [1:0]  DAC_DIN;
    logic        busy;
    logic        frame_done;
`ifdef DAC_SPI_POWERDOWN_EN
    logic [3:0]  pd_mode = 4'b0000;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [23:0] cap_bits [2];
    int          cap_falls [2];
    int          cap_sync_low [2];
    bit          cap_sclk_low [2];
    bit          cap_din_hi [2];
    int          cap_done_cyc;
    int          cap_done_cnt;
    int          cap_busy_cnt;
    int          cap_ready;

    always #5 dataclk = ~dataclk;

    dac_spi_frame_tx #(
        .CLK_DIV          (2),
        .SYNC_HIGH_CYCLES (2)
    ) dut (
        .dataclk    (dataclk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dac_word_1 (dac_word_1),
        .dac_word_2 (dac_word_2),
        .DAC_en     (DAC_en),
`ifdef DAC_SPI_POWERDOWN_EN
        .pd_mode    (pd_mode),
`endif
        .DAC_SYNC   (DAC_SYNC),
        .DAC_SCLK   (DAC_SCLK),
        .DAC_DIN    (DAC_DIN),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with inputs set; cycle k is sampled at the negedge k cycles after the accept edge.
    task automatic capture(input bit drop_valid, input bit scramble);
        logic [1:0] prev_sclk;
        prev_sclk = 2'b11;
        for (int n = 0; n < 2; n++) begin
            cap_bits[n]     = '0;
            cap_falls[n]    = 0;
            cap_sync_low[n] = 0;
            cap_sclk_low[n] = 1'b0;
            cap_din_hi[n]   = 1'b0;
        end
        cap_done_cyc = 0;
        cap_done_cnt = 0;
        cap_busy_cnt = 0;
        cap_ready    = 0;
        @(posedge dataclk);
        for (int k = 1; k <= 200 && cap_ready == 0; k++) begin
            @(negedge dataclk);
            if (drop_valid) in_valid = 1'b0;
            if (scramble && k <= 96) begin
                dac_word_1 = 16'(k * 37 + 5);
                DAC_en     = 2'(k);
            end
            for (int n = 0; n < 2; n++) begin
                if (prev_sclk[n] && !DAC_SCLK[n]) begin
                    cap_bits[n] = {cap_bits[n][22:0], DAC_DIN[n]};
                    cap_falls[n]++;
                end
                if (!DAC_SYNC[n] && cap_sync_low[n] == 0) cap_sync_low[n] = k;
                if (!DAC_SCLK[n]) cap_sclk_low[n] = 1'b1;
                if (DAC_DIN[n]) cap_din_hi[n] = 1'b1;
            end
            prev_sclk = DAC_SCLK;
            if (frame_done) begin
                cap_done_cnt++;
                if (cap_done_cyc == 0) cap_done_cyc = k;
            end
            if (busy) cap_busy_cnt++;
            if (in_ready) cap_ready = k;
        end
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        dac_word_1 = '0;
        dac_word_2 = '0;
        DAC_en     = 2'b00;

        // Reset state
        repeat (3) @(negedge dataclk);
        chk("rst_sync", 32'(DAC_SYNC), 32'h3);
        chk("rst_sclk", 32'(DAC_SCLK), 32'h3);
        chk("rst_din", 32'(DAC_DIN), 32'h0);
        chk("rst_ready", 32'(in_ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(frame_done), 32'h0);
        reset = 1'b1;
        repeat (2) @(negedge dataclk);

        // Test 1: basic frame, both channels enabled
        dac_word_1 = 16'hA5C3;
        dac_word_2 = 16'h0001;
        DAC_en     = 2'b11;
        in_valid   = 1'b1;
        capture(1'b1, 1'b0);
        chk("t1_sync1_lat", 32'(cap_sync_low[0]), 32'd1);
        chk("t1_sync2_lat", 32'(cap_sync_low[1]), 32'd1);
        chk("t1_falls1", 32'(cap_falls[0]), 32'd24);
        chk("t1_falls2", 32'(cap_falls[1]), 32'd24);
        chk("t1_bits1", 32'(cap_bits[0]), 32'h00A5C3);
        chk("t1_bits2", 32'(cap_bits[1]), 32'h000001);
        chk("t1_done_cyc", 32'(cap_done_cyc), 32'd97);
        chk("t1_done_cnt", 32'(cap_done_cnt), 32'd1);
        chk("t1_busy_cnt", 32'(cap_busy_cnt), 32'd98);
        chk("t1_ready_cyc", 32'(cap_ready), 32'd99);
        chk("t1_idle_sync", 32'(DAC_SYNC), 32'h3);

        // Test 2: in_valid held high, back-to-back frames every 99 cycles
        dac_word_1 = 16'h1000;
        dac_word_2 = 16'h2000;
        in_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            capture(1'b0, 1'b0);
            chk("t2_sync_lat", 32'(cap_sync_low[0]), 32'd1);
            chk("t2_bits1", 32'(cap_bits[0]), 32'h001000 + 32'(i));
            chk("t2_bits2", 32'(cap_bits[1]), 32'h002000 + 32'(i));
            chk("t2_ready_cyc", 32'(cap_ready), 32'd99);
            dac_word_1 = 16'h1001 + 16'(i);
            dac_word_2 = 16'h2001 + 16'(i);
            if (i == 2) in_valid = 1'b0;
        end

        // Test 3: channel 1 disabled
        dac_word_1 = 16'hFFFF;
        dac_word_2 = 16'hFFFF;
        DAC_en     = 2'b10;
        in_valid   = 1'b1;
        capture(1'b1, 1'b0);
        chk("t3_ch1_sync", 32'(cap_sync_low[0]), 32'd0);
        chk("t3_ch1_sclk", 32'(cap_sclk_low[0]), 32'd0);
        chk("t3_ch1_din", 32'(cap_din_hi[0]), 32'd0);
        chk("t3_bits2", 32'(cap_bits[1]), 32'h00FFFF);
        chk("t3_falls2", 32'(cap_falls[1]), 32'd24);
        chk("t3_done_cyc", 32'(cap_done_cyc), 32'd97);
        chk("t3_ready_cyc", 32'(cap_ready), 32'd99);

        // Test 4: asynchronous reset at cycle 40 of a frame
        dac_word_1 = 16'hFFFF;
        dac_word_2 = 16'hFFFF;
        DAC_en     = 2'b11;
        in_valid   = 1'b1;
        @(posedge dataclk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge dataclk);
            in_valid = 1'b0;
        end
        chk("t4_pre_sync", 32'(DAC_SYNC), 32'h0);
        chk("t4_pre_busy", 32'(busy), 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("t4_rst_sync", 32'(DAC_SYNC), 32'h3);
        chk("t4_rst_sclk", 32'(DAC_SCLK), 32'h3);
        chk("t4_rst_din", 32'(DAC_DIN), 32'h0);
        chk("t4_rst_ready", 32'(in_ready), 32'h1);
        chk("t4_rst_busy", 32'(busy), 32'h0);
        @(negedge dataclk);
        reset = 1'b1;
        repeat (3) @(negedge dataclk);
        chk("t4_no_resume", 32'(busy), 32'h0);
        dac_word_1 = 16'h1234;
        dac_word_2 = 16'hBEEF;
        in_valid   = 1'b1;
        capture(1'b1, 1'b0);
        chk("t4_bits1", 32'(cap_bits[0]), 32'h001234);
        chk("t4_bits2", 32'(cap_bits[1]), 32'h00BEEF);
        chk("t4_falls1", 32'(cap_falls[0]), 32'd24);
        chk("t4_ready_cyc", 32'(cap_ready), 32'd99);

        // Test 5: inputs churning mid-frame do not disturb the latched frame
        dac_word_1 = 16'h3C5A;
        dac_word_2 = 16'h7E81;
        DAC_en     = 2'b11;
        in_valid   = 1'b1;
        capture(1'b1, 1'b1);
        chk("t5_bits1", 32'(cap_bits[0]), 32'h003C5A);
        chk("t5_bits2", 32'(cap_bits[1]), 32'h007E81);
        chk("t5_falls1", 32'(cap_falls[0]), 32'd24);
        chk("t5_ready_cyc", 32'(cap_ready), 32'd99);

`ifdef DAC_SPI_POWERDOWN_EN
        // Test 6: power-down field in bits 17:16
        dac_word_1 = 16'h8000;
        dac_word_2 = 16'h8000;
        DAC_en     = 2'b11;
        pd_mode    = 4'b1101;
        in_valid   = 1'b1;
        capture(1'b1, 1'b0);
        chk("t6_bits1", 32'(cap_bits[0]), 32'h018000);
        chk("t6_bits2", 32'(cap_bits[1]), 32'h038000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dac_spi_frame_tx.md
Name: dac_spi_frame_tx

Overview:
Downstream serializer that takes the two 16-bit DAC output words produced by the DAC processing path (HPF, threshold and window FSM) and drives the two external 16-bit SPI DACs. One frame is 24 bits, MSB first:
- bits 23:18 = 0
- bits 17:16 = power-down field
- bits 15:0 = data word

Both channels shift in lockstep from one FSM. A valid/ready handshake lets the upstream sample sequencer hand over one word pair per frame.

Parameters:
CLK_DIV, 2, dataclk cycles per SCLK half-period (legal range 1..15)
SYNC_HIGH_CYCLES, 2, dataclk cycles DAC_SYNC is held high after each frame (legal range 1..15)
FRAME_BITS, 24, bits per SPI frame (fixed; not to be overridden)

Ports:
dataclk  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  word pair on dac_word_1/2 is valid
in_ready  out  1  block can accept a word pair (high only in IDLE)
dac_word_1  in  16  channel 1 DAC code (offset binary)
dac_word_2  in  16  channel 2 DAC code (offset binary)
DAC_en  in  2  per-channel enable, sampled at accept
DAC_SYNC  out  2  per-channel frame select, active low
DAC_SCLK  out  2  per-channel serial clock, idles high
DAC_DIN  out  2  per-channel serial data
busy  out  1  high in SHIFT and GAP
frame_done  out  1  one-cycle pulse on the first GAP cycle

Behaviour:
- Clock and reset: single clock dataclk. reset is asynchronous and active-low.
- Reset values: state=IDLE, DAC_SYNC=2'b11, DAC_SCLK=2'b11, DAC_DIN=2'b00, in_ready=1, busy=0, frame_done=0, all counters=0, shift registers=0.
- All outputs are registered except in_ready, which is decoded from state==IDLE.
- States: IDLE, SHIFT, GAP.
- IDLE -> SHIFT on in_valid & in_ready at a dataclk edge. On that edge:
  - load shift_n = {6'b0, pd_n, dac_word_n}; pd_n = 2'b00 unless the optional feature is compiled in;
  - latch en_q = DAC_en;
  - clear bit_cnt and div_cnt.
- SHIFT: first cycle after accept, DAC_SYNC[n] goes low for each enabled channel. Latency from accept edge to SYNC low is 1 cycle.
- Each bit lasts 2*CLK_DIV cycles:
  - first CLK_DIV cycles: SCLK high, DIN = current MSB;
  - next CLK_DIV cycles: SCLK low, DIN unchanged;
  - then shift left, bit_cnt+1.
  - The DAC samples on the SCLK falling edge; the SYNC-to-first-fall setup is CLK_DIV cycles.
- SHIFT -> GAP after the low half of bit_cnt==23. On that transition: DAC_SYNC=2'b11, DAC_SCLK=2'b11, DAC_DIN=0, frame_done pulses for 1 cycle.
- GAP lasts SYNC_HIGH_CYCLES, then -> IDLE.
- Accept-to-accept interval is 48*CLK_DIV + SYNC_HIGH_CYCLES + 1 cycles; 99 with defaults.
- Disabled channel (en_q[n]=0): DAC_SYNC[n], DAC_SCLK[n] stay high and DAC_DIN[n]=0 for the whole frame. Frame timing is unchanged.
- DAC_en=2'b00 at accept still runs a full-length frame with no bus activity. frame_done still pulses.
- in_valid while busy is ignored; no data is lost upstream because in_ready=0. dac_word_n and DAC_en changing mid-frame do not affect the current frame.
- in_valid high in the cycle the FSM enters IDLE is accepted on the next edge. There are no idle-cycle bubbles beyond the one IDLE cycle.
- reset asserted mid-frame: outputs immediately return to their reset values. The truncated frame is not resumed. After reset deassertion, the first accepted pair starts a fresh frame.
- Counter widths: bit_cnt 5 bits; div_cnt 4 bits; gap_cnt 4 bits. No counter wraps inside a legal parameter range.

Optional Feature:
DAC_SPI_POWERDOWN_EN
- When defined: adds input pd_mode (4 bits; [1:0] channel 1, [3:2] channel 2), sampled at accept and placed in frame bits 17:16 of the corresponding channel (00 normal, 01 1k to GND, 10 100k to GND, 11 tri-state).
- When undefined: the port is absent and bits 17:16 are always 00.

Decomposition:
- Shared package dac_spi_pkg:
  - state enum {IDLE, SHIFT, GAP};
  - FRAME_BITS=24;
  - PD_NORMAL=2'b00, PD_1K=2'b01, PD_100K=2'b10, PD_TRISTATE=2'b11;
  - frame-assembly function {6'b0, pd, word}.
- One natural sub-module, dac_spi_lane: per-channel shift register plus SYNC/SCLK/DIN output flops. It is instantiated twice, driven by a common FSM/counter core in dac_spi_frame_tx.

Test Plan:
1. Reset, dac_word_1=16'hA5C3, dac_word_2=16'h0001, DAC_en=2'b11, in_valid pulse:
   - SYNC low 1 cycle after accept;
   - 24 SCLK falls;
   - bits sampled at falls are 24'h00A5C3 / 24'h000001;
   - frame_done at cycle 97 after accept;
   - in_ready back at cycle 99.
2. in_valid held high continuously with incrementing words: accept interval is exactly 99 cycles; no word skipped or duplicated.
3. DAC_en=2'b10, word=16'hFFFF:
   - channel 1 SYNC/SCLK stay high and DIN=0 throughout;
   - channel 2 frame is correct;
   - frame_done still pulses.
4. reset asserted at cycle 40 of a frame: all outputs go to reset values asynchronously (before next edge); next accepted frame is correct and complete.
5. Change dac_word_1 and DAC_en every cycle during SHIFT: transmitted frame equals the values latched at accept.
6. With DAC_SPI_POWERDOWN_EN defined, pd_mode=4'b1101, words 16'h8000/16'h8000: frames are 24'h018000 (channel 1) and 24'h038000 (channel 2).
